prog_counter: RTL and testbench

Parametrised up/down modulo counter: the next-generation general timing element for the alarm system, replacing fixed-width counters. Counts clock50 cycles qualified by En, up or down, against a run-time terminal value, in free-running or one-shot mode. Emits a one-cycle terminal-count pulse and a sticky done flag. Used for entry/exit delays, siren timeouts and keypad lockout timers.

---
 rtl/prog_counter.sv | 101 ++++++++++
 tb/tb_prog_counter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Up/down modulo timer with terminal pulse and sticky one-shot done.
// Define PROG_COUNTER_PRESCALER_EN to divide steps by PRESCALE.
module prog_counter #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 50000
) (
    input  logic             clock50,
    input  logic             Mr,
    input  logic             En,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_down,
    input  logic             one_shot,
    output logic [WIDTH-1:0] Qout,
    output logic             Tc,
    output logic             done
);

    logic             step;
    logic             term;
    logic [WIDTH-1:0] next_q;
    logic             at_top;
    logic             at_zero;
    logic             above;

    assign at_top  = (Qout >= limit);
    assign at_zero = (Qout == '0);
    assign above   = (Qout > limit);

`ifdef PROG_COUNTER_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PW'(PRESCALE - 1));
    assign step = En && !load_en && !done && tick;

    always_ff @(posedge clock50 or posedge Mr) begin
        if (Mr) begin
            pre_cnt <= '0;
        end else if (load_en) begin
            pre_cnt <= '0;
        end else if (En && !done) begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign step = En && !load_en && !done;
`endif

    // A count parked above limit (from a load) falls back to limit on a down step.
    always_comb begin
        term   = 1'b0;
        next_q = Qout;
        unique case (1'b1)
            up_down && at_top: begin
                term   = 1'b1;
                next_q = one_shot ? limit : '0;
            end
            up_down && !at_top: begin
                next_q = Qout + 1'b1;
            end
            !up_down && at_zero: begin
                term   = 1'b1;
                next_q = one_shot ? '0 : limit;
            end
            !up_down && !at_zero && above: begin
                next_q = limit;
            end
            default: begin
                next_q = Qout - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock50 or posedge Mr) begin
        if (Mr) begin
            Qout <= '0;
            Tc   <= 1'b0;
            done <= 1'b0;
        end else if (load_en) begin
            Qout <= load_value;
            Tc   <= 1'b0;
            done <= 1'b0;
        end else if (step) begin
            Qout <= next_q;
            Tc   <= term;
            if (term && one_shot) begin
                done <= 1'b1;
            end
        end else begin
            Tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Randomised and directed bench for prog_counter against a behavioural model.
// Build with or without PROG_COUNTER_PRESCALER_EN; PRESCALE is fixed at 4.
module tb_prog_counter;

    localparam int W  = 4;
    localparam int PS = 4;

    logic         clock50 = 1'b0;
    logic         Mr;
    logic         En;
    logic         load_en;
    logic [W-1:0] load_value;
    logic [W-1:0] limit;
    logic         up_down;
    logic         one_shot;
    logic [W-1:0] Qout;
    logic         Tc;
    logic         done;

    int checks   = 0;
    int failures = 0;

    int mq;
    int mtc;
    int mdone;
    int mpre;
    int msteps;

    prog_counter #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clock50    (clock50),
        .Mr         (Mr),
        .En         (En),
        .load_en    (load_en),
        .load_value (load_value),
        .limit      (limit),
        .up_down    (up_down),
        .one_shot   (one_shot),
        .Qout       (Qout),
        .Tc         (Tc),
        .done       (done)
    );

    always #5 clock50 = ~clock50;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq    = 0;
        mtc   = 0;
        mdone = 0;
        mpre  = 0;
    endtask

    // Behavioural view of one rising edge, using the inputs as sampled.
    task automatic model_edge();
        bit ok;
        int lim;
        lim = int'(limit);
        if (load_en) begin
            mq    = int'(load_value);
            mtc   = 0;
            mdone = 0;
            mpre  = 0;
            return;
        end
        ok = En && (mdone == 0);
`ifdef PROG_COUNTER_PRESCALER_EN
        if (ok) begin
            if (mpre == PS - 1) begin
                mpre = 0;
            end else begin
                mpre = mpre + 1;
                ok   = 1'b0;
            end
        end
`endif
        mtc = 0;
        if (!ok) return;
        msteps++;
        if (up_down) begin
            if (mq >= lim) begin
                mtc   = 1;
                mq    = one_shot ? lim : 0;
                mdone = one_shot ? 1 : 0;
            end else begin
                mq = mq + 1;
            end
        end else begin
            if (mq == 0) begin
                mtc   = 1;
                mq    = one_shot ? 0 : lim;
                mdone = one_shot ? 1 : 0;
            end else if (mq > lim) begin
                mq = lim;
            end else begin
                mq = mq - 1;
            end
        end
    endtask

    task automatic tick_cycle();
        @(posedge clock50);
        model_edge();
        #1;
        check("qout", 32'(Qout), mq);
        check("tc", 32'(Tc), mtc);
        check("done", 32'(done), mdone);
    endtask

    task automatic run_steps(input int n);
        int target;
        int budget;
        target = msteps + n;
        budget = n * PS * 2 + 8;
        En = 1'b1;
        while (msteps < target && budget > 0) begin
            tick_cycle();
            budget--;
        end
        if (msteps < target) check("step_budget", msteps, target);
    endtask

    task automatic do_load(input int v);
        load_en    = 1'b1;
        load_value = W'(v);
        tick_cycle();
        load_en    = 1'b0;
    endtask

    initial begin
        Mr         = 1'b1;
        En         = 1'b0;
        load_en    = 1'b0;
        load_value = '0;
        limit      = W'(9);
        up_down    = 1'b1;
        one_shot   = 1'b0;
        msteps     = 0;
        model_reset();
        #3;
        check("rst_q", 32'(Qout), 0);
        check("rst_tc", 32'(Tc), 0);
        check("rst_done", 32'(done), 0);
        #9;
        Mr = 1'b0;

        // Reset mid-count takes effect immediately, then restarts from 0.
        run_steps(5);
        check("pre_rst_q", 32'(Qout), 5);
        #2;
        Mr = 1'b1;
        #1;
        model_reset();
        check("async_q", 32'(Qout), 0);
        check("async_tc", 32'(Tc), 0);
        check("async_done", 32'(done), 0);
        #1;
        Mr = 1'b0;
        run_steps(1);
        check("post_rst_q", 32'(Qout), 1);

        // Up wrap with limit 9.
        En = 1'b0;
        do_load(0);
        for (int i = 1; i <= 12; i++) begin
            run_steps(1);
            check("wrap_q", 32'(Qout), i % 10);
            check("wrap_tc", 32'(Tc), 32'(i % 10 == 0));
        end

        // Down one-shot from 3.
        up_down  = 1'b0;
        one_shot = 1'b1;
        En       = 1'b0;
        do_load(3);
        for (int i = 2; i >= 0; i--) begin
            run_steps(1);
            check("dn_q", 32'(Qout), i);
            check("dn_tc", 32'(Tc), 0);
        end
        run_steps(1);
        check("os_q", 32'(Qout), 0);
        check("os_tc", 32'(Tc), 1);
        check("os_done", 32'(done), 1);
        for (int i = 0; i < 5 * PS; i++) tick_cycle();
        check("frz_q", 32'(Qout), 0);
        check("frz_tc", 32'(Tc), 0);
        check("frz_done", 32'(done), 1);
        do_load(0);
        check("ld_clr_done", 32'(done), 0);

        // Load beats step; loads above limit.
        one_shot = 1'b0;
        up_down  = 1'b1;
        En       = 1'b1;
        do_load(7);
        check("ld_q", 32'(Qout), 7);
        check("ld_tc", 32'(Tc), 0);
        do_load(12);
        run_steps(1);
        check("hi_up_q", 32'(Qout), 0);
        check("hi_up_tc", 32'(Tc), 1);
        up_down = 1'b0;
        do_load(12);
        run_steps(1);
        check("hi_dn_q", 32'(Qout), 9);
        check("hi_dn_tc", 32'(Tc), 0);

        // limit 0: every step terminal.
        up_down = 1'b1;
        limit   = '0;
        do_load(0);
        for (int i = 0; i < 4; i++) begin
            run_steps(1);
            check("lim0_q", 32'(Qout), 0);
            check("lim0_tc", 32'(Tc), 1);
        end

`ifdef PROG_COUNTER_PRESCALER_EN
        limit = W'(15);
        En    = 1'b1;
        do_load(0);
        for (int i = 0; i < 3; i++) tick_cycle();
        check("ps_wait_q", 32'(Qout), 0);
        tick_cycle();
        check("ps_step_q", 32'(Qout), 1);
        tick_cycle();
        tick_cycle();
        En = 1'b0;
        tick_cycle();
        tick_cycle();
        En = 1'b1;
        tick_cycle();
        check("ps_gap_q", 32'(Qout), 1);
        tick_cycle();
        check("ps_gap_step", 32'(Qout), 2);
        tick_cycle();
        tick_cycle();
        do_load(0);
        for (int i = 0; i < 3; i++) tick_cycle();
        check("ps_ld_wait", 32'(Qout), 0);
        tick_cycle();
        check("ps_ld_step", 32'(Qout), 1);
`endif

        // Random traffic against the model.
        limit = W'($urandom_range(15));
        for (int i = 0; i < 1500; i++) begin
            En         = ($urandom_range(3) != 0);
            load_en    = ($urandom_range(29) == 0);
            load_value = W'($urandom_range(15));
            if ($urandom_range(15) == 0) limit = W'($urandom_range(15));
            if ($urandom_range(7) == 0) up_down = ~up_down;
            if ($urandom_range(19) == 0) one_shot = ~one_shot;
            if ($urandom_range(99) == 0) begin
                #2;
                Mr = 1'b1;
                #1;
                model_reset();
                check("rnd_rst_q", 32'(Qout), 0);
                Mr = 1'b0;
            end
            tick_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
